// File: rtl/down_counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_ctrl_pkg
// Description : Shared definitions for the down counter controller: the
//               controller state encoding and the default widths used by
//               the top level and its prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
package down_counter_ctrl_pkg;

    // Default width of the programmed period / counter value.
    localparam int DEF_WIDTH = 4;

    // Default width of the decrement-rate prescaler.
    localparam int DEF_PRE_W = 8;

    // Controller states. Encoding is fixed so that it stays stable across
    // tools and is recognisable on a waveform.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // A sequence is in progress whenever the controller has left IDLE.
    function automatic logic state_is_busy(input state_e s);
        return (s != ST_IDLE);
    endfunction

endpackage : down_counter_ctrl_pkg
`default_nettype wire

// File: rtl/dc_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : dc_prescaler
// Description : Loadable down-divider. Counts down from a loaded value while
//               enabled and produces a one-cycle tick when the count is zero.
//               The count is reloaded from 'value' on a tick or on 'load',
//               so it never wraps below zero. With value P and enable held
//               high, ticks are spaced P+1 cycles apart.
//
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset (count -> 0)
//               load   - reload the count from 'value' on the next edge
//               enable - allow counting / ticking this cycle
//               value  - reload value P
//               tick   - high when count == 0 and enable == 1
// Revision    : 1.0 - initial release
// ============================================================================
module dc_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [PRE_W-1:0] value,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == '0);

    // A tick only happens at zero, so the decrement branch never sees zero
    // and the counter cannot underflow.
    always_comb begin
        cnt_d = cnt_q;
        if (load || tick) begin
            cnt_d = value;
        end else if (enable) begin
            cnt_d = cnt_q - PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : dc_prescaler
`default_nettype wire

// File: rtl/down_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_ctrl
// Description : Initiator-side controller for a down counter. On an accepted
//               start it captures period N, prescale P and the reload mode,
//               strobes 'latch' for one cycle to load N into the counter,
//               then issues 'dec' pulses every P+1 cycles until the counter
//               reports zero, at which point it pulses 'done'. In reload
//               mode the sequence restarts from LOAD; in one-shot mode it
//               returns to IDLE. 'abort' returns to IDLE from any state.
//
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               start    - begin a sequence (sampled only in IDLE)
//               period   - count value N, captured on accepted start
//               prescale - dec spacing divider P, captured on accepted start
//               reload   - 1 = auto-reload, 0 = one-shot
//               abort    - terminate any sequence, return to IDLE
//               zero     - registered zero flag from the down counter
//               cnt_in   - value for the counter IN port (captured N)
//               latch    - counter load strobe
//               dec      - counter decrement strobe
//               busy     - high whenever not IDLE
//               done     - one-cycle pulse when the counter reaches zero
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter_ctrl
    import down_counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] period,
    input  logic [PRE_W-1:0] prescale,
    input  logic             reload,
    input  logic             abort,
    input  logic             zero,
    output logic [WIDTH-1:0] cnt_in,
    output logic             latch,
    output logic             dec,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------
    // State and captured configuration
    // ------------------------------------------------------------------
    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] period_d;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             mode_q;
    logic             mode_d;

    // Prescaler control
    logic             ps_load;
    logic             ps_enable;
    logic [PRE_W-1:0] ps_value;
    logic             ps_tick;

    dc_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ps_load),
        .enable (ps_enable),
        .value  (ps_value),
        .tick   (ps_tick)
    );

    assign cnt_in = period_q;
    assign busy   = state_is_busy(state_q);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        pre_d     = pre_q;
        mode_d    = mode_q;
        latch     = 1'b0;
        dec       = 1'b0;
        done      = 1'b0;
        ps_load   = 1'b0;
        ps_enable = 1'b0;
        ps_value  = pre_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    period_d = period;
                    pre_d    = prescale;
                    mode_d   = reload;
                    // The prescaler is loaded from the live input because
                    // pre_q only takes the new value on this same edge.
                    ps_load  = 1'b1;
                    ps_value = prescale;
                    state_d  = ST_LOAD;
                end
            end

            ST_LOAD: begin
                latch   = 1'b1;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (zero) begin
                    // Mealy on the registered zero flag: completion is
                    // reported in the first cycle zero is seen.
                    done = 1'b1;
                    if (mode_q) begin
                        // Re-arm the prescaler so the next run starts with
                        // a full P-cycle wait before its first dec.
                        ps_load = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    ps_enable = 1'b1;
                    dec       = ps_tick;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a start in IDLE: strobes
        // are suppressed in the abort cycle and the mode is cleared so no
        // reload can follow.
        if (abort) begin
            state_d   = ST_IDLE;
            period_d  = period_q;
            pre_d     = pre_q;
            mode_d    = 1'b0;
            latch     = 1'b0;
            dec       = 1'b0;
            done      = 1'b0;
            ps_load   = 1'b0;
            ps_enable = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            pre_q    <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            pre_q    <= pre_d;
            mode_q   <= mode_d;
        end
    end

endmodule : down_counter_ctrl
`default_nettype wire

// File: tb/tb_down_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_down_counter_ctrl
// Description : Directed bench for down_counter_ctrl with a behavioural down
//               counter attached. Cycle 0 is the cycle in which start is
//               presented in IDLE; outputs are sampled once per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_down_counter_ctrl;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic [3:0] period   = 4'd0;
    logic [7:0] prescale = 8'd0;
    logic       reload   = 1'b0;
    logic       abort    = 1'b0;
    logic       zero;
    logic [3:0] cnt_in;
    logic       latch;
    logic       dec;
    logic       busy;
    logic       done;

    // Attached down counter: latch has priority, dec stops at zero.
    logic [3:0] model_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_cnt <= 4'd0;
        end else if (latch) begin
            model_cnt <= cnt_in;
        end else if (dec && (model_cnt != 4'd0)) begin
            model_cnt <= model_cnt - 4'd1;
        end
    end

    assign zero = (model_cnt == 4'd0);

    down_counter_ctrl #(
        .WIDTH (4),
        .PRE_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .period   (period),
        .prescale (prescale),
        .reload   (reload),
        .abort    (abort),
        .zero     (zero),
        .cnt_in   (cnt_in),
        .latch    (latch),
        .dec      (dec),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Per-cycle logs of one run
    logic       lat_log  [4096];
    logic       dec_log  [4096];
    logic       done_log [4096];
    logic       busy_log [4096];
    logic [3:0] cin_log  [4096];
    logic [3:0] cnt_log  [4096];
    logic [63:0] lat_m;
    logic [63:0] dec_m;
    logic [63:0] done_m;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Called at a falling edge. Runs ncyc cycles, start presented in cycle 0;
    // optional abort in cycle ab_c and a second start (period rs_n) in rs_c.
    task automatic run(input int ncyc, input logic [3:0] n, input logic [7:0] p,
                       input logic rl, input int ab_c, input int rs_c,
                       input logic [3:0] rs_n);
        lat_m  = '0;
        dec_m  = '0;
        done_m = '0;
        for (int c = 0; c < ncyc; c++) begin
            start    = (c == 0) || (c == rs_c);
            period   = (c == rs_c) ? rs_n : n;
            prescale = p;
            reload   = rl;
            abort    = (c == ab_c);
            #1;
            lat_log[c]  = latch;
            dec_log[c]  = dec;
            done_log[c] = done;
            busy_log[c] = busy;
            cin_log[c]  = cnt_in;
            cnt_log[c]  = model_cnt;
            if (c < 64) begin
                lat_m[c]  = latch;
                dec_m[c]  = dec;
                done_m[c] = done;
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    int nd;
    int first_dec;
    int last_dec;
    int prev_dec;
    int gap_bad;
    int done_at;

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {latch, dec, done, busy, cnt_in}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- 1: reset mid-RUN (N=5, P=2) ----------------
        run(4, 4'd5, 8'd2, 1'b0, -1, -1, 4'd0);
        chk("t1_latch_mask", lat_m, 64'h2);
        chk("t1_cnt_in_c1", cin_log[1], 64'h5);
        // Cycle 4 is 2+P: first dec pulse, busy high.
        #1;
        chk("t1_busy_dec_before_rst", {busy, dec}, 64'h3);
        rst_n = 1'b0;
        #1;
        chk("t1_outputs_in_rst", {latch, dec, done, busy, cnt_in}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("t1_idle_after_rst", {busy, latch, dec, done}, 64'h0);
        @(negedge clk);

        // ---------------- 2: one-shot N=3, P=1 ----------------
        run(10, 4'd3, 8'd1, 1'b0, -1, -1, 4'd0);
        chk("t2_latch_mask", lat_m, 64'h2);
        chk("t2_cnt_in_c1", cin_log[1], 64'h3);
        chk("t2_dec_mask", dec_m, 64'hA8);
        chk("t2_counter_c4_c6_c8", {cnt_log[4], cnt_log[6], cnt_log[8]}, 64'h210);
        chk("t2_done_mask", done_m, 64'h100);
        chk("t2_busy_c8_c9", {busy_log[8], busy_log[9]}, 64'h2);

        // ---------------- 3: N=0, P=4 ----------------
        run(5, 4'd0, 8'd4, 1'b0, -1, -1, 4'd0);
        chk("t3_latch_mask", lat_m, 64'h2);
        chk("t3_dec_mask", dec_m, 64'h0);
        chk("t3_done_mask", done_m, 64'h4);
        chk("t3_busy_c3", busy_log[3], 64'h0);

        // ---------------- 4: reload N=2, P=0, abort in cycle 9 ----------------
        run(12, 4'd2, 8'd0, 1'b1, 9, -1, 4'd0);
        chk("t4_latch_mask", lat_m, 64'h22);
        chk("t4_dec_mask", dec_m, 64'hCC);
        chk("t4_done_mask", done_m, 64'h110);
        chk("t4_busy_c9_c10_c11", {busy_log[9], busy_log[10], busy_log[11]}, 64'h4);

        // ---------------- 5: start while busy ----------------
        run(9, 4'd4, 8'd0, 1'b0, -1, 3, 4'd9);
        chk("t5_latch_mask", lat_m, 64'h2);
        chk("t5_cnt_in_c4_c8", {cin_log[4], cin_log[8]}, 64'h44);
        chk("t5_dec_mask", dec_m, 64'h3C);
        chk("t5_done_mask", done_m, 64'h40);

        // ---------------- 6: N=15, P=255 ----------------
        run(3845, 4'd15, 8'd255, 1'b0, -1, -1, 4'd0);
        nd        = 0;
        first_dec = -1;
        last_dec  = -1;
        prev_dec  = -1;
        gap_bad   = 0;
        done_at   = -1;
        for (int c = 0; c < 3845; c++) begin
            if (dec_log[c]) begin
                nd++;
                if (first_dec < 0) first_dec = c;
                if ((prev_dec >= 0) && ((c - prev_dec) != 256)) gap_bad++;
                prev_dec = c;
                last_dec = c;
            end
            if (done_log[c] && (done_at < 0)) done_at = c;
        end
        chk("t6_dec_count", nd, 64'd15);
        chk("t6_first_dec", first_dec, 64'd257);
        chk("t6_last_dec", last_dec, 64'd3841);
        chk("t6_dec_gaps", gap_bad, 64'd0);
        chk("t6_done_cycle", done_at, 64'd3842);
        chk("t6_counter_at_done", cnt_log[3842], 64'h0);
        chk("t6_busy_after_done", busy_log[3843], 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_down_counter_ctrl
`default_nettype wire
